// File: rtl/tcdm_sram_responder.sv
// Single-port TCDM slave over a word array, with LFSR-driven grant stalls and 1-cycle responses.
// Define TCDM_SRAM_RESPONDER_COUNTERS_EN to build the granted read/write counters.
module tcdm_sram_responder #(
  parameter int unsigned MEMORY_SIZE  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned STALL_THRESH = 26,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic        stall_en_i,
  input  logic        tcdm_req_i,
  input  logic [31:0] tcdm_add_i,
  input  logic        tcdm_wen_i,
  input  logic [3:0]  tcdm_be_i,
  input  logic [31:0] tcdm_data_i,
  output logic        tcdm_gnt_o,
  output logic [31:0] tcdm_r_data_o,
  output logic        tcdm_r_valid_o,
  output logic [31:0] cnt_rd_o,
  output logic [31:0] cnt_wr_o
);
  localparam int unsigned DEPTH     = MEMORY_SIZE / 4;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEMORY_SIZE);
  localparam logic [7:0]  THRESH    = 8'(STALL_THRESH);

  logic [15:0]      lfsr_q, lfsr_d;
  logic             stall, gnt, in_range;
  logic [32:0]      diff;
  logic [IDX_W-1:0] idx;
  logic             r_valid_q;
  logic [31:0]      r_data_q;
  logic [31:0]      mem [DEPTH];

  // 33-bit subtraction so the borrow flags addresses below the base
  always_comb begin
    diff     = {1'b0, tcdm_add_i} - {1'b0, BASE_ADDR};
    in_range = ~diff[32] && (diff[31:0] < MEM_BYTES);
    idx      = diff[IDX_W+1:2];
  end

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    stall  = stall_en_i & (lfsr_q[7:0] < THRESH);
    gnt    = tcdm_req_i & enable_i & ~stall & ~clear_i & ~rst_i;
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                       lfsr_q <= LFSR_SEED;
    else if (clear_i)                lfsr_q <= LFSR_SEED;
    else if (enable_i && stall_en_i) lfsr_q <= lfsr_d;
  end

  // Storage is not reset; out-of-range writes are dropped
  always_ff @(posedge clk_i) begin
    if (gnt && !tcdm_wen_i && in_range) begin
      for (int k = 0; k < 4; k++)
        if (tcdm_be_i[k]) mem[idx][8*k +: 8] <= tcdm_data_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= gnt;
      if (gnt) r_data_q <= !tcdm_wen_i ? 32'h0 : (in_range ? mem[idx] : 32'hDEADBEEF);
    end
  end

`ifdef TCDM_SRAM_RESPONDER_COUNTERS_EN
  logic [31:0] cnt_rd_q, cnt_wr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_rd_q <= '0;
      cnt_wr_q <= '0;
    end else if (clear_i) begin
      cnt_rd_q <= '0;
      cnt_wr_q <= '0;
    end else if (gnt) begin
      if (tcdm_wen_i) cnt_rd_q <= cnt_rd_q + 32'd1;
      else            cnt_wr_q <= cnt_wr_q + 32'd1;
    end
  end

  assign cnt_rd_o = cnt_rd_q;
  assign cnt_wr_o = cnt_wr_q;
`else
  assign cnt_rd_o = '0;
  assign cnt_wr_o = '0;
`endif

endmodule
